// File: rtl/if_fetch.sv
// if_fetch: PC owner and single-outstanding instruction fetcher feeding IF/ID,
// with hazard stall, branch flush/redirect and stale-response draining.
module if_fetch #(
  parameter int PC_width = 32,
  parameter int inst_width = 32,
  parameter int num_width = 5,
  parameter logic [PC_width-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic [PC_width-1:0]   branch_target,
  output logic                  imem_req,
  output logic [PC_width-1:0]   imem_addr,
  input  logic                  imem_rvalid,
  input  logic [inst_width-1:0] imem_rdata,
  output logic                  valid_out,
  output logic [PC_width-1:0]   PC_out,
  output logic [PC_width-1:0]   PC4_out,
  output logic [inst_width-1:0] inst_out,
  output logic [num_width-1:0]  rd_num1_out,
  output logic [num_width-1:0]  rd_num2_out,
  output logic [num_width-1:0]  wr_num_out
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;
  state_t state, nxt_state;
  logic [PC_width-1:0] pc, nxt_pc, tgt, pc4;
  logic [inst_width-1:0] hold_buf;
  logic req, ld_buf;
  assign tgt = branch_target & ~PC_width'(3);
  assign pc4 = pc + PC_width'(4);
  always_comb begin
    nxt_state = state;
    nxt_pc = pc;
    req = 1'b0;
    ld_buf = 1'b0;
    valid_out = 1'b0;
    inst_out = '0;
    case (state)
      IDLE: begin
        req = 1'b1;
        nxt_pc = flush ? tgt : pc;
        nxt_state = WAIT;
      end
      WAIT:
        if (flush) begin
          nxt_pc = tgt;
          req = imem_rvalid;
          nxt_state = imem_rvalid ? WAIT : DRAIN;
        end else if (imem_rvalid) begin
          valid_out = 1'b1;
          inst_out = imem_rdata;
          req = !hazard;
          ld_buf = hazard;
          nxt_pc = hazard ? pc : pc4;
          nxt_state = hazard ? HOLD : WAIT;
        end
      HOLD: begin
        valid_out = !flush;
        inst_out = flush ? '0 : hold_buf;
        req = flush || !hazard;
        nxt_pc = flush ? tgt : hazard ? pc : pc4;
        nxt_state = (flush || !hazard) ? WAIT : HOLD;
      end
      DRAIN: begin
        nxt_pc = flush ? tgt : pc;
        req = imem_rvalid;
        nxt_state = imem_rvalid ? WAIT : DRAIN;
      end
      default: nxt_state = IDLE;
    endcase
  end
  // every request goes to the address the PC is about to hold
  assign imem_req = req & rst_n;
  assign imem_addr = nxt_pc;
  assign PC_out = pc;
  assign PC4_out = pc4;
  assign rd_num1_out = inst_out[15 +: num_width];
  assign rd_num2_out = inst_out[20 +: num_width];
  assign wr_num_out = inst_out[7 +: num_width];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state <= nxt_state;
      pc <= nxt_pc;
      if (ld_buf) hold_buf <= imem_rdata;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed cycle-by-cycle bench for if_fetch with a latency-programmable memory responder.
module tb_if_fetch;
  logic clk = 1'b0, rst_n = 1'b0, hazard = 1'b0, flush = 1'b0;
  logic [31:0] branch_target = '0, imem_addr, imem_rdata = '0, PC_out, PC4_out, inst_out;
  logic imem_req, imem_rvalid = 1'b0, valid_out;
  logic [4:0] rd_num1_out, rd_num2_out, wr_num_out;
  int n_chk = 0, n_fail = 0, lat = 1, cnt = 0;
  logic pend = 1'b0, req_seen = 1'b0, rv_seen = 1'b0;
  logic [31:0] paddr = '0, addr_seen = '0;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .hazard(hazard), .flush(flush), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_out(valid_out), .PC_out(PC_out), .PC4_out(PC4_out), .inst_out(inst_out),
    .rd_num1_out(rd_num1_out), .rd_num2_out(rd_num2_out), .wr_num_out(wr_num_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h00500093 : a == 32'h4 ? 32'h002081B3 : 32'hA000_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic h, input logic f, input logic [31:0] t);
    @(negedge clk);
    if (rv_seen) pend = 1'b0;
    else if (pend && cnt > 0) cnt--;
    if (req_seen) begin
      pend = 1'b1;
      paddr = addr_seen;
      cnt = lat - 1;
    end
    hazard = h;
    flush = f;
    branch_target = t;
    imem_rvalid = pend && cnt == 0;
    imem_rdata = imem_rvalid ? mem(paddr) : '0;
    #1;
    req_seen = imem_req;
    addr_seen = imem_addr;
    rv_seen = imem_rvalid;
  endtask

  task automatic outs(input string tag, input logic req, input logic [31:0] addr,
                      input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    chk({tag, ".pc"}, PC_out, pc);
    chk({tag, ".pc4"}, PC4_out, pc + 32'd4);
    chk({tag, ".inst"}, inst_out, inst);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 outs("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0); outs("A", 1, 32'h0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0); outs("B", 1, 32'h4, 1, 32'h0, 32'h00500093);
    chk("B.wr", {27'b0, wr_num_out}, 32'd1);
    chk("B.rs1", {27'b0, rd_num1_out}, 32'd0);
    cyc(1, 0, 0); outs("C", 0, 32'h0, 1, 32'h4, 32'h002081B3);
    chk("C.rs1", {27'b0, rd_num1_out}, 32'd1);
    chk("C.rs2", {27'b0, rd_num2_out}, 32'd2);
    chk("C.wr", {27'b0, wr_num_out}, 32'd3);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0); outs("hold", 0, 32'h0, 1, 32'h4, 32'h002081B3);
    end
    cyc(0, 0, 0); outs("F", 1, 32'h8, 1, 32'h4, 32'h002081B3);
    lat = 3;
    cyc(0, 1, 32'h103); outs("G", 0, 32'h0, 0, 32'h8, 32'h0);
    cyc(0, 0, 0); outs("H", 0, 32'h0, 0, 32'h100, 32'h0);
    cyc(0, 0, 0); outs("I", 1, 32'h100, 0, 32'h100, 32'h0);
    lat = 1;
    cyc(0, 0, 0); outs("J", 1, 32'h104, 1, 32'h100, 32'hA000_0100);
    cyc(0, 1, 32'h40); outs("K", 1, 32'h40, 0, 32'h104, 32'h0);
    cyc(1, 0, 0); outs("L", 0, 32'h0, 1, 32'h40, 32'hA000_0040);
    cyc(1, 1, 32'h80); outs("M", 1, 32'h80, 0, 32'h40, 32'h0);
    cyc(0, 0, 0); outs("N", 1, 32'h84, 1, 32'h80, 32'hA000_0080);
    lat = 3;
    cyc(0, 0, 0); outs("O", 0, 32'h0, 0, 32'h84, 32'h0);
    #2 rst_n = 1'b0;
    imem_rvalid = 1'b0;
    pend = 1'b0;
    req_seen = 1'b0;
    rv_seen = 1'b0;
    #1 outs("rstmid", 0, 32'h0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 1;
    cyc(0, 0, 0); outs("P", 1, 32'h0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0); outs("Q", 1, 32'h4, 1, 32'h0, 32'h00500093);
    cyc(0, 1, 32'hFFFF_FFFF); outs("R", 1, 32'hFFFF_FFFC, 0, 32'h4, 32'h0);
    cyc(0, 0, 0); outs("S", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h5FFF_FFFC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
